// File: rtl/seven_seg_pkg.sv
// Shared glyphs, anode patterns and digit-index type for the stopwatch display scanner.
// Glyphs are active-low with bit 0 = segment a and bit 6 = segment g.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {
    DIG_SEC2 = 2'd0,
    DIG_SEC1 = 2'd1,
    DIG_MIN2 = 2'd2,
    DIG_MIN1 = 2'd3
  } dig_e;

  typedef struct packed {
    logic [2:0] min1;
    logic [3:0] min2;
    logic [2:0] sec1;
    logic [3:0] sec2;
  } digits_t;

  // Active-low anode pattern that lights only the given digit position.
  function automatic logic [3:0] anode_for(input dig_e idx);
    logic [3:0] pattern;
    case (idx)
      DIG_SEC2: pattern = 4'b1110;
      DIG_SEC1: pattern = 4'b1101;
      DIG_MIN2: pattern = 4'b1011;
      DIG_MIN1: pattern = 4'b0111;
      default:  pattern = ANODES_OFF;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational 4-bit value to active-low seven-segment glyph (module bcd_to_seg).
// Values above 9 render as a lone dash on segment g.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] glyph
);

  // Glyph lookup.
  always_comb begin
    glyph = SEG_DASH;
    case (value)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode display scanner with per-frame digit snapshot and anti-ghost blanking.
// Optional pause/minute-set blinking is built only when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_SLOTS  = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] min1,
  input  logic [3:0] min2,
  input  logic [2:0] sec1,
  input  logic [3:0] sec2,
  input  logic       pause,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_r;
  dig_e             idx_r;
  digits_t          snap_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  logic             slot_end_s;
  logic             blank_s;
  logic             hide_s;
  logic [3:0]       digit_s;
  logic [6:0]       glyph_s;

  assign slot_end_s = (cnt_r == CNT_W'(SCAN_DIV - 1));
  assign blank_s    = (cnt_r < CNT_W'(BLANK_CYCLES));

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= DIG_SEC2;
    end else if (slot_end_s) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= dig_e'(idx_r + 2'd1);
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Capture all four digits together as the index wraps back to the seconds units.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_r <= '0;
    end else if (slot_end_s && (idx_r == DIG_MIN1)) begin
      snap_r <= '{min1: min1, min2: min2, sec1: sec1, sec2: sec2};
    end else begin
      snap_r <= snap_r;
    end
  end

  // Select the snapshot digit for the current index.
  always_comb begin
    digit_s = 4'd0;
    case (idx_r)
      DIG_SEC2: digit_s = snap_r.sec2;
      DIG_SEC1: digit_s = {1'b0, snap_r.sec1};
      DIG_MIN2: digit_s = snap_r.min2;
      DIG_MIN1: digit_s = {1'b0, snap_r.min1};
      default:  digit_s = 4'd0;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .value (digit_s),
    .glyph (glyph_s)
  );

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BLK_W = (BLINK_SLOTS > 2) ? $clog2(BLINK_SLOTS) : 1;

  logic [BLK_W-1:0] blink_cnt_r;
  logic             blink_on_r;

  // Blink phase flips after every BLINK_SLOTS slot wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_on_r  <= 1'b1;
    end else if (slot_end_s) begin
      if (blink_cnt_r == BLK_W'(BLINK_SLOTS - 1)) begin
        blink_cnt_r <= {BLK_W{1'b0}};
        blink_on_r  <= ~blink_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + {{(BLK_W-1){1'b0}}, 1'b1};
        blink_on_r  <= blink_on_r;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_on_r  <= blink_on_r;
    end
  end

  // In the off phase pause darkens everything; minute-set darkens only the minute digits.
  always_comb begin
    hide_s = 1'b0;
    if (blink_on_r) begin
      hide_s = 1'b0;
    end else if (pause) begin
      hide_s = 1'b1;
    end else if (sel && ((idx_r == DIG_MIN2) || (idx_r == DIG_MIN1))) begin
      hide_s = 1'b1;
    end else begin
      hide_s = 1'b0;
    end
  end
`else
  logic unused_blink_inputs_s;
  assign unused_blink_inputs_s = pause ^ sel;
  assign hide_s = 1'b0;
`endif

  // Registered display outputs; one cycle behind the counter/index that selects them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_r  <= ANODES_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= 1'b1;
    end else if (blank_s || hide_s) begin
      an_r  <= ANODES_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= anode_for(idx_r);
      seg_r <= glyph_s;
      dp_r  <= (idx_r == DIG_MIN2) ? 1'b0 : 1'b1;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=8, BLANK_CYCLES=2, BLINK_SLOTS=2.
// Blink scenarios compile in when SEVEN_SEG_BLINK_EN is defined.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] min1 = 3'd0;
  logic [3:0] min2 = 4'd0;
  logic [2:0] sec1 = 3'd0;
  logic [3:0] sec2 = 4'd0;
  logic       pause = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;
  int pos = -1;

  seven_seg_scan #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .BLINK_SLOTS  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .min1    (min1),
    .min2    (min2),
    .sec1    (sec1),
    .sec2    (sec2),
    .pause   (pause),
    .sel     (sel),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected {an, seg, dp} for scan position p (state index since reset release).
  function automatic logic [11:0] expect_out(input int p, input logic [15:0] digs, input logic hide);
    int c;
    int i;
    c = p % 8;
    i = (p / 8) % 4;
    if (c < 2 || hide) return {4'hF, 7'h7F, 1'b1};
    return {~(4'b0001 << i), glyph(digs[i*4 +: 4]), (i == 2) ? 1'b0 : 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pos = -1;
  endtask

  task automatic test_reset();
    min1 = 3'd5; min2 = 4'd9; sec1 = 3'd5; sec2 = 4'd9;
    #2 reset_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
      end
    end
    reset_n = 1'b1;
    pos = -1;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (pos < 2 && an !== 4'hF) begin
        bad++;
        $display("FAIL first_blank pos=%0d an=%b want=1111", pos, an);
      end else if (pos == 2 && (an !== 4'b1110 || seg !== 7'h40)) begin
        bad++;
        $display("FAIL first_lit an=%b seg=%h want an=1110 seg=40", an, seg);
      end
    end
  endtask

  task automatic test_scan();
    logic [11:0] e;
    logic [15:0] digs;
    int lows[4] = '{0, 0, 0, 0};
    while (pos < 95) begin
      tick();
      digs = (pos < 32) ? 16'h0000 : 16'h5959;
      e = expect_out(pos, digs, 1'b0);
      total++;
      if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
        bad++;
        $display("FAIL scan pos=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 pos, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (pos >= 32 && pos < 64) begin
        for (int b = 0; b < 4; b++) if (an[b] === 1'b0) lows[b]++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      total++;
      if (lows[b] != 6) begin
        bad++;
        $display("FAIL anode_low_len an[%0d] low=%0d want=6", b, lows[b]);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [11:0] e;
    logic [15:0] digs;
    min1 = 3'd0; min2 = 4'd0; sec1 = 3'd2; sec2 = 4'd3;
    do_reset();
    while (pos < 95) begin
      tick();
      if (pos < 32)      digs = 16'h0000;
      else if (pos < 64) digs = 16'h0023;
      else               digs = 16'h0034;
      e = expect_out(pos, digs, 1'b0);
      total++;
      if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
        bad++;
        $display("FAIL snapshot pos=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 pos, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (pos == 40) begin
        sec2 = 4'd4;
        sec1 = 3'd3;
      end
    end
  endtask

  task automatic test_dash_dp();
    logic [11:0] e;
    min1 = 3'd1; min2 = 4'd2; sec1 = 3'd3; sec2 = 4'hC;
    do_reset();
    while (pos < 63) begin
      tick();
      e = expect_out(pos, (pos < 32) ? 16'h0000 : 16'h123C, 1'b0);
      total++;
      if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
        bad++;
        $display("FAIL dash_dp pos=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 pos, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    while (pos < 84) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_async an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pos = -1;
    while (pos < 15) begin
      tick();
      e = expect_out(pos, 16'h0000, 1'b0);
      total++;
      if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
        bad++;
        $display("FAIL reset_resume pos=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 pos, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

`ifdef SEVEN_SEG_BLINK_EN
  task automatic test_blink();
    logic [11:0] e;
    logic hide;
    for (int mode = 0; mode < 3; mode++) begin
      min1 = 3'd1; min2 = 4'd2; sec1 = 3'd3; sec2 = 4'd4;
      pause = (mode == 1);
      sel = (mode == 0);
      do_reset();
      while (pos < 63) begin
        tick();
        hide = (((pos / 16) % 2) == 1) && (pause || (sel && ((pos / 8) % 4) >= 2));
        e = expect_out(pos, (pos < 32) ? 16'h0000 : 16'h1234, hide);
        total++;
        if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
          bad++;
          $display("FAIL blink mode=%0d pos=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                   mode, pos, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
    pause = 1'b0;
    sel = 1'b0;
  endtask
`else
  task automatic test_blink_ignored();
    logic [11:0] e;
    min1 = 3'd1; min2 = 4'd2; sec1 = 3'd3; sec2 = 4'd4;
    pause = 1'b1;
    sel = 1'b1;
    do_reset();
    while (pos < 63) begin
      tick();
      e = expect_out(pos, (pos < 32) ? 16'h0000 : 16'h1234, 1'b0);
      total++;
      if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
        bad++;
        $display("FAIL blink_off pos=%0d an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 pos, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
    pause = 1'b0;
    sel = 1'b0;
  endtask
`endif

  task automatic test_one_hot();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      tick();
      total++;
      if (!(an === 4'b1111 || an === 4'b1110 || an === 4'b1101 ||
            an === 4'b1011 || an === 4'b0111)) begin
        bad++;
        $display("FAIL one_hot n=%0d an=%b want 1111 or one bit low", n, an);
      end
      min1 = 3'($urandom_range(0, 5));
      min2 = 4'($urandom_range(0, 15));
      sec1 = 3'($urandom_range(0, 5));
      sec2 = 4'($urandom_range(0, 15));
      pause = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if (!reset_n) begin
        #1;
        total++;
        if (an !== 4'hF) begin
          bad++;
          $display("FAIL one_hot_reset n=%0d an=%b want=1111", n, an);
        end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_dash_dp();
    test_reset_mid();
`ifdef SEVEN_SEG_BLINK_EN
    test_blink();
`else
    test_blink_ignored();
`endif
    test_one_hot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
